// File: rtl/usb_dpdm_pkg.sv
// usb_dpdm_pkg: shared types and the line-symbol encoder for the DP/DM transmitter.
package usb_dpdm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PACKET,
        ST_FLUSH,
        ST_EOP_SE0,
        ST_EOP_J
    } dpdm_tx_state_t;

    typedef enum logic [1:0] {
        SYM_J,
        SYM_K,
        SYM_SE0,
        SYM_Z
    } line_sym_t;

    // {DP,DM} for a line symbol; SYM_Z yields 00 and is tri-stated by the caller
    function automatic logic [1:0] sym_to_dpdm(input line_sym_t sym, input logic low_speed);
        logic [1:0] v;
        case (sym)
            SYM_J:   v = low_speed ? 2'b01 : 2'b10;
            SYM_K:   v = low_speed ? 2'b10 : 2'b01;
            default: v = 2'b00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dpdm_preload_fifo.sv
// dpdm_preload_fifo: shift-register FIFO preloaded with the SYNC pattern; the
// preloaded entries delay the NRZI stream so SYNC goes out first.
module dpdm_preload_fifo #(
    parameter int unsigned           SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]   SYNC_PATTERN = 8'b0010_1010
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_reload,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_bit,
    output logic                           o_head,
    output logic [$clog2(SYNC_LEN+1)-1:0]  o_cnt
);

    localparam int unsigned CW = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] r_mem;
    logic [SYNC_LEN-1:0] w_mem_next;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_pop;
    logic [CW-1:0]       w_cnt_next;
    logic                w_pop_ok;
    logic                w_push_ok;

    // pop shifts toward the head first; a push then lands just past the remaining entries
    always_comb begin
        w_mem_next = r_mem;
        w_cnt_pop  = r_cnt;
        w_pop_ok   = i_pop && (r_cnt != '0);
        if (w_pop_ok) begin
            w_mem_next = r_mem >> 1;
            w_cnt_pop  = r_cnt - CW'(1);
        end
        w_push_ok  = i_push && (w_cnt_pop != CW'(SYNC_LEN));
        w_cnt_next = w_cnt_pop;
        if (w_push_ok) begin
            for (int unsigned i = 0; i < SYNC_LEN; i++) begin
                if (CW'(i) == w_cnt_pop) begin
                    w_mem_next[i] = i_bit;
                end
            end
            w_cnt_next = w_cnt_pop + CW'(1);
        end
    end

    // storage and occupancy; reset or reload restores the SYNC preload
    always_ff @(posedge i_clk) begin
        if (i_rst || i_reload) begin
            r_mem <= SYNC_PATTERN;
            r_cnt <= CW'(SYNC_LEN);
        end else begin
            r_mem <= w_mem_next;
            r_cnt <= w_cnt_next;
        end
    end

    assign o_head = r_mem[0];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/usb_dpdm_tx.sv
// usb_dpdm_tx: DP/DM line driver placed after the NRZI encoder. Delays the
// stream through a SYNC-preloaded buffer, then appends SE0/J EOP.
// Optional feature: define USB_DPDM_TX_ABORT_EN to add the 'abort' input.
module usb_dpdm_tx
    import usb_dpdm_pkg::*;
#(
    parameter int unsigned           SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0]   SYNC_PATTERN = 8'b0010_1010,
    parameter int unsigned           EOP_SE0_LEN  = 2,
    parameter int unsigned           EOP_J_LEN    = 1,
    parameter bit                    LOW_SPEED    = 1'b0,
    parameter bit                    IDLE_DRIVE_J = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic nrzi_sending,
    input  logic in_bit,
`ifdef USB_DPDM_TX_ABORT_EN
    input  logic abort,
`endif
    output logic DP,
    output logic DM,
    output logic busy,
    output logic out_done
);

    localparam int unsigned EOP_MAX  = (EOP_SE0_LEN > EOP_J_LEN) ? EOP_SE0_LEN : EOP_J_LEN;
    localparam int unsigned SCW      = $clog2(EOP_MAX + 1);
    localparam int unsigned CW       = $clog2(SYNC_LEN + 1);
    localparam logic [SCW-1:0] SE0_LAST = SCW'(EOP_SE0_LEN - 1);
    localparam logic [SCW-1:0] J_LAST   = SCW'(EOP_J_LEN - 1);
    localparam line_sym_t IDLE_SYM   = IDLE_DRIVE_J ? SYM_J : SYM_Z;

    dpdm_tx_state_t r_state;
    dpdm_tx_state_t w_next;
    logic [SCW-1:0] r_sym_cnt;
    logic [SCW-1:0] w_sym_cnt_next;
    line_sym_t      w_sym;
    line_sym_t      w_head_sym;
    logic           w_push;
    logic           w_pop;
    logic           w_reload;
    logic           w_done;
    logic           w_busy_next;
    logic           w_head;
    logic [CW-1:0]  w_cnt;
    logic [1:0]     w_line;
    logic           r_dp;
    logic           r_dm;
    logic           r_oe;
    logic           r_busy;
    logic           r_done;

    dpdm_preload_fifo #(
        .SYNC_LEN     (SYNC_LEN),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_fifo (
        .i_clk    (clock),
        .i_rst    (reset),
        .i_reload (w_reload),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_bit    (in_bit),
        .o_head   (w_head),
        .o_cnt    (w_cnt)
    );

    assign w_head_sym = w_head ? SYM_J : SYM_K;

    // next state, buffer control and the symbol to register this cycle
    always_comb begin
        w_next         = r_state;
        w_sym_cnt_next = r_sym_cnt;
        w_sym          = IDLE_SYM;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_reload       = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (nrzi_sending) begin
                    w_push = 1'b1;
                    w_pop  = 1'b1;
                    w_sym  = w_head_sym;
                    w_next = ST_PACKET;
                end
            end
            ST_PACKET: begin
                w_pop = 1'b1;
                w_sym = w_head_sym;
                if (nrzi_sending) begin
                    w_push = 1'b1;
                end else begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_pop = 1'b1;
                w_sym = w_head_sym;
                if (w_cnt == CW'(1)) begin
                    w_next         = ST_EOP_SE0;
                    w_sym_cnt_next = '0;
                end
            end
            ST_EOP_SE0: begin
                w_sym = SYM_SE0;
                if (r_sym_cnt == SE0_LAST) begin
                    w_next         = ST_EOP_J;
                    w_sym_cnt_next = '0;
                end else begin
                    w_sym_cnt_next = r_sym_cnt + SCW'(1);
                end
            end
            ST_EOP_J: begin
                w_sym = SYM_J;
                if (r_sym_cnt == J_LAST) begin
                    w_done         = 1'b1;
                    w_reload       = 1'b1;
                    w_next         = ST_IDLE;
                    w_sym_cnt_next = '0;
                end else begin
                    w_sym_cnt_next = r_sym_cnt + SCW'(1);
                end
            end
            default: begin
                w_next         = ST_IDLE;
                w_sym_cnt_next = '0;
            end
        endcase
`ifdef USB_DPDM_TX_ABORT_EN
        // the abort cycle itself emits the first SE0, so the counter starts at one
        if (abort && ((r_state == ST_PACKET) || (r_state == ST_FLUSH))) begin
            w_push   = 1'b0;
            w_pop    = 1'b0;
            w_reload = 1'b1;
            w_sym    = SYM_SE0;
            if (EOP_SE0_LEN == 1) begin
                w_next         = ST_EOP_J;
                w_sym_cnt_next = '0;
            end else begin
                w_next         = ST_EOP_SE0;
                w_sym_cnt_next = SCW'(1);
            end
        end
`endif
        w_busy_next = (w_next != ST_IDLE) || w_done;
    end

    assign w_line = sym_to_dpdm(w_sym, LOW_SPEED);

    // FSM state and EOP symbol counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sym_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_sym_cnt <= w_sym_cnt_next;
        end
    end

    // registered line symbol and status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            {r_dp, r_dm} <= sym_to_dpdm(IDLE_SYM, LOW_SPEED);
            r_oe         <= (IDLE_SYM != SYM_Z);
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            {r_dp, r_dm} <= w_line;
            r_oe         <= (w_sym != SYM_Z);
            r_busy       <= w_busy_next;
            r_done       <= w_done;
        end
    end

    assign DP       = r_oe ? r_dp : 1'bz;
    assign DM       = r_oe ? r_dm : 1'bz;
    assign busy     = r_busy;
    assign out_done = r_done;

endmodule
